// File: rtl/sram_pixel_writer.sv
// Queues pixel write requests in a small FIFO and replays them to an asynchronous SRAM
// as SETUP/WRITE/HOLD strobe sequences, yielding the bus whenever the display reader owns it.
module sram_pixel_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pix_valid,
    input  logic [ADDR_W-1:0]             pix_addr,
    input  logic [15:0]                   pix_data,
    output logic                          pix_ready,
    input  logic                          vga_busy,
    output logic [ADDR_W-1:0]             sram_addrW,
    output logic [15:0]                   sram_dqW,
    output logic                          ce_n,
    output logic                          oe_n,
    output logic                          we_n,
    output logic                          ub_n,
    output logic                          lb_n,
    output logic                          wr_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [1:0]                    fsm_state
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic               can_start;

    // Handshake: a pixel is taken on a rising edge where pix_valid && pix_ready;
    // pix_ready depends only on registered occupancy, never on pix_valid.
    assign pix_ready  = (count != CNT_W'(FIFO_DEPTH));
    assign push       = pix_valid && pix_ready;
    assign can_start  = (count != '0) && !vga_busy;
    assign fifo_count = count;
    assign fsm_state  = state;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pix_addr, pix_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Address/data are captured once at the pop and held through WRITE and HOLD,
    // giving setup and hold margin around the we_n pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_addrW <= '0;
            sram_dqW   <= '0;
        end else if (pop) begin
            {sram_addrW, sram_dqW} <= fifo_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (can_start) begin
                    pop        = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: state_next = WRITE;
            WRITE: state_next = HOLD;
            HOLD: begin
                if (can_start) begin
                    pop        = 1'b1;
                    state_next = SETUP;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset releases we_n immediately.
    assign we_n    = (state != WRITE);
    assign oe_n    = (state != IDLE);
    assign wr_done = (state == HOLD);
    assign ce_n    = 1'b0;
    assign ub_n    = 1'b0;
    assign lb_n    = 1'b0;

endmodule

// File: tb/tb_sram_pixel_writer.sv
// Bench for sram_pixel_writer: fixed vector table, hand-written corner sequences and
// random traffic, all checked against a transaction-level queue model.
module tb_sram_pixel_writer;

    localparam int DEPTH = 4;
    localparam int AW    = 20;

    logic            clk;
    logic            rst;
    logic            pix_valid;
    logic [AW-1:0]   pix_addr;
    logic [15:0]     pix_data;
    logic            pix_ready;
    logic            vga_busy;
    logic [AW-1:0]   sram_addrW;
    logic [15:0]     sram_dqW;
    logic            ce_n, oe_n, we_n, ub_n, lb_n;
    logic            wr_done;
    logic [2:0]      fifo_count;
    logic [1:0]      fsm_state;

    int checks = 0;
    int errors = 0;

    sram_pixel_writer #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .vga_busy   (vga_busy),
        .sram_addrW (sram_addrW),
        .sram_dqW   (sram_dqW),
        .ce_n       (ce_n),
        .oe_n       (oe_n),
        .we_n       (we_n),
        .ub_n       (ub_n),
        .lb_n       (lb_n),
        .wr_done    (wr_done),
        .fifo_count (fifo_count),
        .fsm_state  (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending pixels in acceptance order, plus the age of the write in
    // flight (0 = none, 1..3 = cycles since it started; the third cycle may start the next).
    logic [AW+15:0] exp_q[$];
    int             phase;
    logic [AW-1:0]  m_addr;
    logic [15:0]    m_data;

    typedef struct {
        logic          valid;
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic          busy;
        logic          e_we_n;
        logic          e_oe_n;
        logic          e_done;
        logic [2:0]    e_cnt;
        logic          e_ready;
        logic [AW-1:0] e_addr;
        logic [15:0]   e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [AW-1:0] a, input logic [15:0] d,
                                input logic b, input logic we, input logic oe, input logic dn,
                                input logic [2:0] c, input logic rdy, input logic [AW-1:0] ea,
                                input logic [15:0] ed);
        vec_t r;
        r.valid = v; r.addr = a; r.data = d; r.busy = b;
        r.e_we_n = we; r.e_oe_n = oe; r.e_done = dn; r.e_cnt = c; r.e_ready = rdy;
        r.e_addr = ea; r.e_data = ed;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        phase  = 0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic model_edge();
        logic accept;
        logic start;
        accept = pix_valid && (exp_q.size() != DEPTH);
        start  = (phase == 0 || phase == 3) && (exp_q.size() > 0) && !vga_busy;
        if (start) begin
            {m_addr, m_data} = exp_q.pop_front();
            phase = 1;
        end else if (phase == 3) begin
            phase = 0;
        end else if (phase != 0) begin
            phase++;
        end
        if (accept) exp_q.push_back({pix_addr, pix_data});
    endtask

    task automatic check_model();
        chk("we_n",       we_n,       (phase == 2) ? 0 : 1);
        chk("oe_n",       oe_n,       (phase == 0) ? 0 : 1);
        chk("wr_done",    wr_done,    (phase == 3) ? 1 : 0);
        chk("fifo_count", fifo_count, exp_q.size());
        chk("pix_ready",  pix_ready,  (exp_q.size() != DEPTH) ? 1 : 0);
        chk("sram_addrW", sram_addrW, m_addr);
        chk("sram_dqW",   sram_dqW,   m_data);
        chk("strobes",    {ce_n, ub_n, lb_n}, 0);
    endtask

    task automatic tick(input logic v, input logic [AW-1:0] a, input logic [15:0] d, input logic b);
        pix_valid = v;
        pix_addr  = a;
        pix_data  = d;
        vga_busy  = b;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        int we_lows;
        rst = 1'b1; pix_valid = 1'b0; pix_addr = '0; pix_data = '0; vga_busy = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_we_n", we_n, 1);
        chk("rst_oe_n", oe_n, 0);
        chk("rst_done", wr_done, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", pix_ready, 1);
        chk("rst_addr", sram_addrW, 0);
        chk("rst_data", sram_dqW, 0);
        chk("rst_strobes", {ce_n, ub_n, lb_n}, 0);
        rst = 1'b0;

        // Single write, then four queued behind vga_busy with a fifth rejected.
        vecs.push_back(mk(1, 'h10,  'hF800, 0, 1, 0, 0, 1, 1, 'h0,   'h0));
        vecs.push_back(mk(0, 0, 0, 0,          1, 1, 0, 0, 1, 'h10,  'hF800));
        vecs.push_back(mk(0, 0, 0, 0,          0, 1, 0, 0, 1, 'h10,  'hF800));
        vecs.push_back(mk(0, 0, 0, 0,          1, 1, 1, 0, 1, 'h10,  'hF800));
        vecs.push_back(mk(0, 0, 0, 0,          1, 0, 0, 0, 1, 'h10,  'hF800));
        vecs.push_back(mk(1, 'h100, 'h1000, 1, 1, 0, 0, 1, 1, 'h10,  'hF800));
        vecs.push_back(mk(1, 'h101, 'h1001, 1, 1, 0, 0, 2, 1, 'h10,  'hF800));
        vecs.push_back(mk(1, 'h102, 'h1002, 1, 1, 0, 0, 3, 1, 'h10,  'hF800));
        vecs.push_back(mk(1, 'h103, 'h1003, 1, 1, 0, 0, 4, 0, 'h10,  'hF800));
        vecs.push_back(mk(1, 'h104, 'h1004, 1, 1, 0, 0, 4, 0, 'h10,  'hF800));
        vecs.push_back(mk(0, 0, 0, 0,          1, 1, 0, 3, 1, 'h100, 'h1000));
        vecs.push_back(mk(0, 0, 0, 0,          0, 1, 0, 3, 1, 'h100, 'h1000));
        vecs.push_back(mk(0, 0, 0, 0,          1, 1, 1, 3, 1, 'h100, 'h1000));
        vecs.push_back(mk(0, 0, 0, 0,          1, 1, 0, 2, 1, 'h101, 'h1001));
        vecs.push_back(mk(0, 0, 0, 0,          0, 1, 0, 2, 1, 'h101, 'h1001));
        vecs.push_back(mk(0, 0, 0, 0,          1, 1, 1, 2, 1, 'h101, 'h1001));
        vecs.push_back(mk(0, 0, 0, 0,          1, 1, 0, 1, 1, 'h102, 'h1002));
        vecs.push_back(mk(0, 0, 0, 0,          0, 1, 0, 1, 1, 'h102, 'h1002));
        vecs.push_back(mk(0, 0, 0, 0,          1, 1, 1, 1, 1, 'h102, 'h1002));
        vecs.push_back(mk(0, 0, 0, 0,          1, 1, 0, 0, 1, 'h103, 'h1003));
        vecs.push_back(mk(0, 0, 0, 0,          0, 1, 0, 0, 1, 'h103, 'h1003));
        vecs.push_back(mk(0, 0, 0, 0,          1, 1, 1, 0, 1, 'h103, 'h1003));
        vecs.push_back(mk(0, 0, 0, 0,          1, 0, 0, 0, 1, 'h103, 'h1003));

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].valid, vecs[i].addr, vecs[i].data, vecs[i].busy);
            chk("vec_we_n",  we_n,       vecs[i].e_we_n);
            chk("vec_oe_n",  oe_n,       vecs[i].e_oe_n);
            chk("vec_done",  wr_done,    vecs[i].e_done);
            chk("vec_count", fifo_count, vecs[i].e_cnt);
            chk("vec_ready", pix_ready,  vecs[i].e_ready);
            chk("vec_addr",  sram_addrW, vecs[i].e_addr);
            chk("vec_data",  sram_dqW,   vecs[i].e_data);
        end

        // vga_busy rising during SETUP: the write in flight completes, the next one waits.
        tick(1, 'h2A000, 'h1234, 0);
        tick(1, 'h2A001, 'h5678, 0);
        chk("busy_setup_oe", oe_n, 1);
        tick(0, 0, 0, 1);
        chk("busy_write_we", we_n, 0);
        chk("busy_write_addr", sram_addrW, 'h2A000);
        tick(0, 0, 0, 1);
        chk("busy_hold_done", wr_done, 1);
        repeat (4) begin
            tick(0, 0, 0, 1);
            chk("busy_wait_we", we_n, 1);
            chk("busy_wait_cnt", fifo_count, 1);
        end
        tick(0, 0, 0, 0);
        chk("busy_resume_addr", sram_addrW, 'h2A001);
        repeat (3) tick(0, 0, 0, 0);

        // Three entries, then push and pop on the same edge across the pointer wrap.
        tick(1, 'h30, 'hA000, 1);
        tick(1, 'h31, 'hA001, 1);
        tick(1, 'h32, 'hA002, 1);
        chk("wrap_cnt3", fifo_count, 3);
        tick(1, 'h33, 'hA003, 0);
        chk("wrap_pushpop_cnt", fifo_count, 3);
        chk("wrap_head", sram_addrW, 'h30);
        repeat (14) tick(0, 0, 0, 0);
        chk("wrap_last", sram_addrW, 'h33);
        chk("wrap_empty", fifo_count, 0);

        // Reset in the middle of the WRITE cycle.
        tick(1, 'h40, 'hB000, 0);
        tick(1, 'h41, 'hB001, 0);
        tick(1, 'h42, 'hB002, 0);
        chk("pre_rst_we", we_n, 0);
        rst = 1'b1;
        pix_valid = 1'b0;
        #1;
        chk("rst_mid_we", we_n, 1);
        chk("rst_mid_cnt", fifo_count, 0);
        chk("rst_mid_ready", pix_ready, 1);
        chk("rst_mid_done", wr_done, 0);
        chk("rst_mid_addr", sram_addrW, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        we_lows = 0;
        repeat (10) begin
            tick(0, 0, 0, 0);
            if (we_n === 1'b0) we_lows++;
        end
        chk("post_rst_no_write", we_lows, 0);

        // Random traffic against the model.
        vga_busy = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic b;
            b = vga_busy;
            if ($urandom_range(0, 7) == 0) b = !b;
            tick($urandom_range(0, 2) != 0, AW'($urandom), 16'($urandom), b);
        end
        repeat (30) tick(0, 0, 0, 0);
        chk("final_empty", fifo_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
